ds_rx_10b: RTL

DS_RX_10B -- requirements
Module: ds_rx_10b

---
 rtl/ds_rx_10b.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ds_rx_10b.sv
// DS-link receiver: synchronises D/S, recovers bits from D xor S transitions,
// assembles 10-bit characters MSB-first and hands them out on a valid/ready port.
module ds_rx_10b #(
    parameter int G_TIMEOUT_CLKS = 64,
    parameter int G_SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D_in,
    input  logic       S_in,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       link_active,
    output logic       overflow,
    output logic       disconnect
);

    localparam int IW = $clog2(G_TIMEOUT_CLKS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(G_TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    logic [G_SYNC_STAGES-1:0] d_sync_q, s_sync_q;
    logic                     par_s, par_q, evt_q, bit_q;
    state_t                   state_q, state_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    // Only the nine earlier bits are stored; the tenth arrives with the event.
    logic [8:0]               shreg_q, shreg_d;
    logic [9:0]               word_s;
    logic [IW-1:0]            idle_q, idle_d;
    logic [9:0]               rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     link_q, link_d;
    logic                     ovf_q, ovf_d;
    logic                     disc_q, disc_d;
    logic                     word_done_s;

    // Plain flop chains for the asynchronous line inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_sync_q <= {G_SYNC_STAGES{1'b0}};
            s_sync_q <= {G_SYNC_STAGES{1'b0}};
        end else begin
            d_sync_q <= {d_sync_q[G_SYNC_STAGES-2:0], D_in};
            s_sync_q <= {s_sync_q[G_SYNC_STAGES-2:0], S_in};
        end
    end

    assign par_s = d_sync_q[G_SYNC_STAGES-1] ^ s_sync_q[G_SYNC_STAGES-1];

    // Bit event: parity of the synchronised pair toggled since the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
            evt_q <= 1'b0;
            bit_q <= 1'b0;
        end else begin
            par_q <= par_s;
            evt_q <= par_s ^ par_q;
            bit_q <= d_sync_q[G_SYNC_STAGES-1];
        end
    end

    // Receiver state, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= 9'd0;
            idle_q     <= {IW{1'b0}};
            rx_data_q  <= 10'd0;
            rx_valid_q <= 1'b0;
            link_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            idle_q     <= idle_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            link_q     <= link_d;
            ovf_q      <= ovf_d;
            disc_q     <= disc_d;
        end
    end

    // Next-state logic: FSM, bit assembly, idle timer and output handshake.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        idle_d      = idle_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        ovf_d       = 1'b0;
        word_done_s = 1'b0;
        word_s      = {shreg_q, bit_q};

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                idle_d = {IW{1'b0}};
                if (evt_q) begin
                    state_d = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (evt_q) begin
                    idle_d = {IW{1'b0}};
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            ST_TIMEOUT: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 4'd0;
                shreg_d   = 9'd0;
                idle_d    = {IW{1'b0}};
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 4'd0;
                shreg_d   = 9'd0;
                idle_d    = {IW{1'b0}};
            end
        endcase

        // Events arriving during the single TIMEOUT cycle are discarded.
        if (evt_q && (state_q != ST_TIMEOUT)) begin
            shreg_d = word_s[8:0];
            if (bit_cnt_q == 4'd9) begin
                bit_cnt_d   = 4'd0;
                word_done_s = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            word_done_s = 1'b0;
        end

        if (word_done_s) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = word_s;
                rx_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            ovf_d = 1'b0;
        end

        link_d = (state_d == ST_RECV);
        disc_d = (state_d == ST_TIMEOUT);
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign link_active = link_q;
    assign overflow    = ovf_q;
    assign disconnect  = disc_q;

endmodule
